// File: rtl/free_list_pkg.sv
//------------------------------------------------------------------------------
// free_list_pkg
//   Sizing constants and the popcount helper shared by the physical-tag
//   free list.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package free_list_pkg;

   localparam int ARCH_NUM = 32;
   localparam int PR_NUM   = 64;
   localparam int FL_SIZE  = PR_NUM - ARCH_NUM;
   localparam int PR       = $clog2(PR_NUM);
   localparam int IDX_W    = $clog2(FL_SIZE);
   localparam int PTR_W    = IDX_W + 1;
   localparam int CNT_W    = $clog2(FL_SIZE + 1);
   localparam int WAYS     = 3;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/free_list.sv
//------------------------------------------------------------------------------
// free_list
//   Circular FIFO of free physical register tags: three-wide allocate at head,
//   three-wide retire at tail, and branch recovery back to the arch head.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module free_list
   import free_list_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WAYS-1:0]          dispatch_req,
   input  logic [WAYS-1:0]          retire_en,
   input  logic [WAYS-1:0][PR-1:0]  retire_told,
   input  logic                     BPRecoverEN,
   output logic [WAYS-1:0][PR-1:0]  maptable_new_pr,
   output logic [WAYS-1:0]          new_pr_valid,
   output logic [CNT_W-1:0]         free_num
`ifdef TEST_MODE
   ,
   output logic [FL_SIZE-1:0][PR-1:0] fl_array_disp,
   output logic [PTR_W-1:0]           head_disp,
   output logic [PTR_W-1:0]           tail_disp
`endif
);

   localparam int SUM_W = CNT_W + 1;

   logic [PR-1:0]    r_entry [FL_SIZE];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W-1:0] r_arch_head;
   logic [1:0]       w_n_alloc;
   logic [1:0]       w_n_ret;

   // Outputs depend only on registered state, so freed tags never bypass.
   always_comb begin
      free_num = CNT_W'(r_tail - r_head);
      for (int i = 0; i < WAYS; i++) begin
         maptable_new_pr[i] = r_entry[r_head[IDX_W-1:0] + IDX_W'(i)];
         new_pr_valid[i]    = free_num > CNT_W'(i);
      end
      w_n_alloc = popcount3(dispatch_req & new_pr_valid);
      w_n_ret   = popcount3(retire_en);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FL_SIZE; i++) begin
            r_entry[i] <= PR'(ARCH_NUM + i);
         end
         r_head      <= '0;
         r_arch_head <= '0;
         r_tail      <= PTR_W'(FL_SIZE);
      end else begin
         for (int i = 0; i < WAYS; i++) begin
            if (retire_en[i]) begin
               r_entry[r_tail[IDX_W-1:0] + IDX_W'(i)] <= retire_told[i];
            end
         end
         r_tail      <= r_tail + PTR_W'(w_n_ret);
         r_arch_head <= r_arch_head + PTR_W'(w_n_ret);
         // Recovery rewinds to the committed point, counting this edge's retires.
         if (BPRecoverEN) begin
            r_head <= r_arch_head + PTR_W'(w_n_ret);
         end else begin
            r_head <= r_head + PTR_W'(w_n_alloc);
         end
      end
   end

`ifdef TEST_MODE
   always_comb begin
      for (int i = 0; i < FL_SIZE; i++) begin
         fl_array_disp[i] = r_entry[i];
      end
      head_disp = r_head;
      tail_disp = r_tail;
   end
`endif

   // Retiring more tags than the list can hold would overwrite live entries.
   property p_no_overflow;
      @(posedge clock) disable iff (reset)
         !BPRecoverEN |->
            (SUM_W'(free_num) + SUM_W'(w_n_ret)) <= (SUM_W'(FL_SIZE) + SUM_W'(w_n_alloc));
   endproperty
   a_no_overflow: assert property (p_no_overflow);

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
//------------------------------------------------------------------------------
// tb_free_list
//   Scoreboard bench for free_list driven by a rename/ROB reference model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_free_list;
   import free_list_pkg::*;

   logic                    clock = 1'b0;
   logic                    reset;
   logic [WAYS-1:0]         dispatch_req;
   logic [WAYS-1:0]         retire_en;
   logic [WAYS-1:0][PR-1:0] retire_told;
   logic                    BPRecoverEN;
   logic [WAYS-1:0][PR-1:0] maptable_new_pr;
   logic [WAYS-1:0]         new_pr_valid;
   logic [CNT_W-1:0]        free_num;

   free_list dut (
      .clock           (clock),
      .reset           (reset),
      .dispatch_req    (dispatch_req),
      .retire_en       (retire_en),
      .retire_told     (retire_told),
      .BPRecoverEN     (BPRecoverEN),
      .maptable_new_pr (maptable_new_pr),
      .new_pr_valid    (new_pr_valid),
      .free_num        (free_num)
   );

   always #5 clock = ~clock;

   typedef struct {
      int r;
      int tag;
      int told;
   } rob_t;

   typedef struct {
      logic [WAYS-1:0][PR-1:0] tags;
      logic [WAYS-1:0]         valid;
      logic [CNT_W-1:0]        free;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Reference model: free tags live in ent[mh .. mt) on unbounded counters;
   // rename state is a speculative map, an arch map and an in-order ROB.
   int   ent [FL_SIZE];
   int   mh, mt, ma;
   int   spec_map [ARCH_NUM];
   int   arch_map [ARCH_NUM];
   rob_t rob[$];
   int   dir_r;

   function automatic exp_t model_out();
      exp_t e;
      int   f;
      f = mt - mh;
      for (int i = 0; i < WAYS; i++) begin
         e.tags[i]  = PR'(ent[(mh + i) % FL_SIZE]);
         e.valid[i] = (f > i);
      end
      e.free = CNT_W'(f);
      return e;
   endfunction

   function automatic bit is_live(input int t);
      for (int j = 0; j < ARCH_NUM; j++) begin
         if (spec_map[j] == t) return 1'b1;
      end
      foreach (rob[k]) begin
         if (rob[k].told == t) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < FL_SIZE; i++) ent[i] = ARCH_NUM + i;
      for (int j = 0; j < ARCH_NUM; j++) begin
         spec_map[j] = j;
         arch_map[j] = j;
      end
      mh = 0;
      ma = 0;
      mt = FL_SIZE;
      rob.delete();
   endtask

   // Reset is applied with random traffic on the other inputs to show it wins.
   task automatic do_reset();
      reset        = 1'b1;
      dispatch_req = 3'b111;
      retire_en    = 3'($urandom_range(0, 1) * 3);
      retire_told  = '{default: PR'($urandom)};
      BPRecoverEN  = 1'($urandom_range(0, 1));
      model_reset();
      exp_q.push_back(model_out());
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic step(input logic [2:0] req, input int nret_in, input bit rec, input bit rnd_r);
      int   f, nalloc, nret, r, tag;
      rob_t e;
      nret = (nret_in > rob.size()) ? rob.size() : nret_in;
      f = mt - mh;
      nalloc = 0;
      for (int i = 0; i < WAYS; i++) begin
         if (req[i] && f > i) nalloc++;
      end
      if (rec) nalloc = 0;

      for (int i = 0; i < nalloc; i++) begin
         checks++;
         if (is_live(int'(maptable_new_pr[i]))) begin
            errors++;
            $display("FAIL dup_grant slot %0d: got tag %0d which is still mapped, required a free tag",
                     i, maptable_new_pr[i]);
         end
      end

      dispatch_req = req;
      retire_en    = 3'((1 << nret) - 1);
      BPRecoverEN  = rec;
      for (int i = 0; i < WAYS; i++) begin
         retire_told[i] = (i < nret) ? PR'(rob[i].told) : PR'($urandom);
      end

      for (int i = 0; i < nret; i++) begin
         e = rob.pop_front();
         arch_map[e.r] = e.tag;
         ent[(mt + i) % FL_SIZE] = e.told;
      end
      mt += nret;
      ma += nret;

      if (rec) begin
         mh = ma;
         rob.delete();
         for (int j = 0; j < ARCH_NUM; j++) spec_map[j] = arch_map[j];
      end else begin
         for (int i = 0; i < nalloc; i++) begin
            tag = ent[(mh + i) % FL_SIZE];
            if (rnd_r) begin
               r = $urandom_range(0, ARCH_NUM - 1);
            end else begin
               r = dir_r;
               dir_r = (dir_r + 1) % ARCH_NUM;
            end
            rob.push_back('{r: r, tag: tag, told: spec_map[r]});
            spec_map[r] = tag;
         end
         mh += nalloc;
      end

      exp_q.push_back(model_out());
      @(negedge clock);
   endtask

   // Monitor: every edge after a pushed expectation, compare the new state.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int i = 0; i < WAYS; i++) begin
            checks++;
            if (maptable_new_pr[i] !== e.tags[i]) begin
               errors++;
               $display("FAIL new_pr[%0d] @%0t: got %0d, expected %0d", i, $time,
                        maptable_new_pr[i], e.tags[i]);
            end
         end
         checks++;
         if (new_pr_valid !== e.valid) begin
            errors++;
            $display("FAIL new_pr_valid @%0t: got %b, expected %b", $time, new_pr_valid, e.valid);
         end
         checks++;
         if (free_num !== e.free) begin
            errors++;
            $display("FAIL free_num @%0t: got %0d, expected %0d", $time, free_num, e.free);
         end
      end
   end

   initial begin
      int k, lim;
      dispatch_req = '0;
      retire_en    = '0;
      retire_told  = '0;
      BPRecoverEN  = 1'b0;
      reset        = 1'b1;

      // Post-reset grant of 32,33,34, then 35 offered with 29 free.
      do_reset();
      dir_r = 1;
      step(3'b111, 0, 1'b0, 1'b0);
      step(3'b000, 0, 1'b0, 1'b0);

      // Drain to empty, request while empty, then a retire appears one edge later.
      do_reset();
      dir_r = 5;
      repeat (10) step(3'b111, 0, 1'b0, 1'b0);
      step(3'b011, 0, 1'b0, 1'b0);
      step(3'b111, 0, 1'b0, 1'b0);
      step(3'b000, 1, 1'b0, 1'b0);
      step(3'b000, 0, 1'b0, 1'b0);

      // Recovery after 6 allocations and 2 retires of Told 1 and 2.
      do_reset();
      dir_r = 1;
      step(3'b111, 0, 1'b0, 1'b0);
      step(3'b111, 0, 1'b0, 1'b0);
      step(3'b000, 2, 1'b0, 1'b0);
      step(3'b000, 0, 1'b1, 1'b0);

      // Recovery with two same-cycle retires and an ignored dispatch.
      step(3'b111, 0, 1'b0, 1'b1);
      step(3'b111, 0, 1'b0, 1'b1);
      step(3'b111, 2, 1'b1, 1'b1);
      step(3'b001, 0, 1'b0, 1'b1);

      // Random legal traffic with a mid-run reset.
      for (int c = 0; c < 200; c++) begin
         if (c == 110) begin
            do_reset();
         end else begin
            k   = $urandom_range(0, 3);
            lim = (rob.size() < 3) ? rob.size() : 3;
            step(3'((1 << k) - 1), $urandom_range(0, lim), ($urandom_range(0, 24) == 0), 1'b1);
         end
      end

      dispatch_req = '0;
      retire_en    = '0;
      BPRecoverEN  = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL: clock  input  1  rising-edge system clock.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: dispatch_req  input  3  per-slot allocate request; requests are packed from slot 0 (e.g. 3'b011 is legal, 3'b101 is illegal).
REQ-004 SHALL: retire_en  input  3  per-slot retire strobe; retires are packed from slot 0.
REQ-005 SHALL: retire_told  input  3x`PR  freed physical tags (Told), slot-aligned with retire_en.
REQ-006 SHALL: BPRecoverEN  input  1  branch-mispredict recovery pulse, shared with map_table.
REQ-007 SHALL: maptable_new_pr  output  3x`PR  next free tags offered to map_table and ROB, slot-aligned.
REQ-008 SHALL: new_pr_valid  output  3  bit i is set when at least i+1 tags are free.
REQ-009 SHALL: free_num  output  $clog2(`FL_SIZE+1)  count of free entries.

Function
REQ-010 SHALL: store free tags in a circular FIFO of `FL_SIZE = `PR_NUM-32 entries (default 32), with head, tail and arch_head pointers of log2(`FL_SIZE)+1 bits each (index plus wrap bit).
REQ-011 SHALL: compute free_num = tail - head, modulo the pointer width.
REQ-012 SHALL: drive maptable_new_pr[i] = entry[head+i] and new_pr_valid[i] = (free_num > i) combinationally, with zero latency.
REQ-013 SHALL: on each edge, advance head by n_alloc = popcount(dispatch_req & new_pr_valid); the allocated tags leave the list in that edge.
REQ-014 SHALL: for each retire_en[i], write retire_told[i] to entry[tail+i], advance tail by popcount(retire_en), and advance arch_head by the same count.
REQ-015 SHALL: not bypass tags freed by retire into allocation; a freed tag is first offered in the cycle after the retire edge.
REQ-016 SHALL: when BPRecoverEN=1, ignore dispatch_req and set head to arch_head + popcount(retire_en) (including same-cycle retires); tail still updates per REQ-014.
REQ-017 SHALL: when dispatch and retire occur in the same cycle, apply both pointer updates independently in one edge.
REQ-018 SHALL: wrap all pointer and index arithmetic modulo 2*`FL_SIZE (pointers) and `FL_SIZE (index).
REQ-019 SHALL: treat free_num = 0 as empty (new_pr_valid = 3'b000, so no allocation occurs).
REQ-020 SHALL: treat a retire that would push free_num above `FL_SIZE as illegal, flagged by a simulation assertion; the RTL does not guard against it.
REQ-021 SHALL: treat dispatch_req bits above new_pr_valid as not granted; upstream stalls on !new_pr_valid, and no partial reorder is performed.

Reset
REQ-022 SHALL: on reset, initialise entry[i] = 32+i for i = 0..`FL_SIZE-1, head = 0, arch_head = 0, and tail = `FL_SIZE (wrap bit set).
REQ-023 SHALL: produce these outputs in the cycle after reset: maptable_new_pr = {34,33,32}, new_pr_valid = 3'b111, free_num = 32.
REQ-024 SHALL: give reset priority over BPRecoverEN, dispatch and retire; reset asserted mid-operation discards all in-flight state.

Structure
REQ-025 SHALL: place `PR, `PR_NUM and `FL_SIZE in verilog/sys_defs.svh and add no new typedefs.
REQ-026 SHALL: be a single flat module with no sub-module; popcount and pointer adders are inline.
REQ-027 SHALL: expose the debug ports fl_array_disp, head_disp and tail_disp under `TEST_MODE only.

Verification
REQ-028 SHALL: cover post-reset state: after reset, dispatch_req = 3'b111 for one cycle -> tags 32,33,34 are granted, and the next cycle shows maptable_new_pr[0] = 35 with free_num = 29.
REQ-029 SHALL: cover drain to empty: dispatch 3'b111 for 10 cycles, then 3'b011 -> free_num = 0 and new_pr_valid = 3'b000; a further request grants nothing.
REQ-030 SHALL: cover no bypass on retire: with the list empty, retire_en = 3'b001 and Told = 5 -> in the same cycle new_pr_valid = 0; in the next cycle maptable_new_pr[0] = 5 with free_num = 1.
REQ-031 SHALL: cover recovery: allocate 6 tags, retire 2 with Told 1 and 2, then pulse BPRecoverEN -> head = arch_head = 2 and free_num = 32 - 2 + 2 = 32.
REQ-032 SHALL: cover simultaneous events: BPRecoverEN with retire_en = 3'b011 in the same cycle -> head = old arch_head + 2, tail advances by 2, and dispatch is ignored.
REQ-033 SHALL: cover wrap-around: run 100 cycles of random legal allocate and retire traffic -> scoreboard holds no duplicate tags and free_num matches the model.
